// File: rtl/iob_wishbone_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : iob_wishbone_mem_responder
// Brief    : Wishbone B4 slave RAM model with CTI/BTE bursts, wait states and
//            out-of-range error responses.
// Revision : 1.0  initial release
// ============================================================================
module iob_wishbone_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o
);

    localparam int                    DEPTH     = 2**MEM_ADDR_W;
    localparam logic [2:0]            CTI_INC   = 3'b010;
    localparam logic [2:0]            CTI_END   = 3'b111;
    localparam logic [3:0]            WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [MEM_ADDR_W-1:0] PTR_ONE   = MEM_ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SINGLE = 3'd2,
        S_BURST  = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t                  state_q;
    state_t                  target_q;
    logic [3:0]              wcnt_q;
    logic [MEM_ADDR_W-1:0]   ptr_q;
    logic                    we_q;
    logic [1:0]              bte_q;
    logic                    ack_q;
    logic                    err_q;
    logic [DATA_W-1:0]       dat_q;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic [MEM_ADDR_W-1:0]   w_idx;
    logic                    w_oor;
    state_t                  w_target;
    logic [MEM_ADDR_W-1:0]   w_wrap_mask;
    logic [MEM_ADDR_W-1:0]   w_ptr_inc;
    logic                    w_mem_we;
    logic                    w_unused;

    assign w_idx    = wb_adr_i[MEM_ADDR_W+1:2];
    assign w_unused = ^wb_adr_i[1:0];

    generate
        if (ADDR_W > MEM_ADDR_W + 2) begin : g_oor
            assign w_oor = |wb_adr_i[ADDR_W-1:MEM_ADDR_W+2];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    always_comb begin
        w_target = S_SINGLE;
        if (w_oor) begin
            w_target = S_ERR;
        end else if (wb_cti_i == CTI_INC) begin
            w_target = S_BURST;
        end
    end

    // Wrap bursts only advance the low index bits; an all-ones mask gives linear mod DEPTH.
    always_comb begin
        case (bte_q)
            2'b01:   w_wrap_mask = MEM_ADDR_W'(3);
            2'b10:   w_wrap_mask = MEM_ADDR_W'(7);
            2'b11:   w_wrap_mask = MEM_ADDR_W'(15);
            default: w_wrap_mask = '1;
        endcase
        w_ptr_inc = (ptr_q & ~w_wrap_mask) | ((ptr_q + PTR_ONE) & w_wrap_mask);
    end

    // Classic writes commit on the ack-raising edge; burst beats on each acked edge.
    always_comb begin
        w_mem_we = 1'b0;
        if (wb_cyc_i && we_q) begin
            if (state_q == S_SINGLE) begin
                w_mem_we = !ack_q;
            end else if (state_q == S_BURST) begin
                w_mem_we = ack_q && wb_stb_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wb_sel_i[b]) begin
                    mem_q[ptr_q][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= S_IDLE;
            target_q <= S_IDLE;
            wcnt_q   <= 4'd0;
            ptr_q    <= '0;
            we_q     <= 1'b0;
            bte_q    <= 2'b00;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
        end else if (!wb_cyc_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wb_stb_i) begin
                        ptr_q  <= w_idx;
                        we_q   <= wb_we_i;
                        bte_q  <= wb_bte_i;
                        wcnt_q <= 4'd0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= w_target;
                        end else begin
                            state_q  <= S_WAIT;
                            target_q <= w_target;
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == WAIT_LAST) begin
                        wcnt_q  <= 4'd0;
                        state_q <= target_q;
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                end
                S_SINGLE: begin
                    if (!ack_q) begin
                        ack_q <= 1'b1;
                        if (!we_q) begin
                            dat_q <= mem_q[ptr_q];
                        end
                    end else begin
                        ack_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_BURST: begin
                    if (!wb_stb_i) begin
                        ack_q <= 1'b0;
                    end else if (ack_q) begin
                        if (wb_cti_i == CTI_END) begin
                            ack_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            ptr_q <= w_ptr_inc;
                            if (!we_q) begin
                                dat_q <= mem_q[w_ptr_inc];
                            end
                        end
                    end else begin
                        // First beat or resume after a stb pause: present the current word.
                        ack_q <= 1'b1;
                        if (!we_q) begin
                            dat_q <= mem_q[ptr_q];
                        end
                    end
                end
                S_ERR: begin
                    if (!err_q) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_wishbone_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_wishbone_mem_responder
// Brief    : Directed bench for the Wishbone memory responder (two instances:
//            no wait states and three wait states).
// Revision : 1.0  initial release
// ============================================================================
module tb_iob_wishbone_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic        cyc0;
    logic        cyc1;
    logic        stb;
    logic [31:0] dat_w;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat0;
    logic [31:0] dat1;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;

    int checks = 0;
    int errors = 0;

    iob_wishbone_mem_responder #(
        .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(12), .WAIT_CYCLES(0)
    ) dut0 (
        .clk_i(clk), .arst_n_i(rst_n), .wb_adr_i(adr), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_dat_i(dat_w),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat0), .wb_ack_o(ack0),
        .wb_err_o(err0)
    );

    iob_wishbone_mem_responder #(
        .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(12), .WAIT_CYCLES(3)
    ) dut1 (
        .clk_i(clk), .arst_n_i(rst_n), .wb_adr_i(adr), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_dat_i(dat_w),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat1), .wb_ack_o(ack1),
        .wb_err_o(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Classic cycle; lat = edges between the sampling edge and the response edge,
    // tail = ack|err one cycle after the response while cyc/stb are still held.
    task automatic classic(input bit dut, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output int lat,
                           output logic r_ack, output logic r_err, output logic tail);
        adr = a; we = w; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00; stb = 1'b1;
        if (dut) cyc1 = 1'b1; else cyc0 = 1'b1;
        lat = -1; r_ack = 1'b0; r_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            r_ack = dut ? ack1 : ack0;
            r_err = dut ? err1 : err0;
            if (r_ack || r_err) break;
        end
        rd = dut ? dat1 : dat0;
        @(posedge clk); #1;
        tail = dut ? (ack1 | err1) : (ack0 | err0);
        cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    // Burst on dut0. vals holds expected read data or write data per beat.
    task automatic burst(input logic w, input logic [31:0] a, input logic [1:0] b, input int n,
                         input logic [31:0] vals [8], input int pause_at, input int rst_at,
                         output int nacks, output int ncyc, output logic end_ack);
        int   done;
        int   paused;
        logic ack_prev;
        logic stb_prev;
        done = 0; paused = 0; ack_prev = 1'b0; stb_prev = 1'b0;
        nacks = 0; ncyc = 0; end_ack = 1'b1;
        adr = a; we = w; bte = b; sel = 4'hF; dat_w = vals[0];
        cti = (n == 1) ? 3'b111 : 3'b010;
        cyc0 = 1'b1; stb = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            ncyc++;
            if (ack_prev && stb_prev) done++;
            if (done == n) begin
                end_ack = ack0;
                break;
            end
            cti   = (done == n - 1) ? 3'b111 : 3'b010;
            dat_w = vals[done];
            if (ack0 && !w) chk($sformatf("burst_rd_beat%0d", done), dat0, vals[done]);
            if (done == rst_at && ack0) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_ack", 32'(ack0), 32'd0);
                chk("rst_err", 32'(err0), 32'd0);
                chk("rst_dat", dat0, 32'd0);
                cyc0 = 1'b0; stb = 1'b0; cti = 3'b000;
                return;
            end
            if (done == pause_at && paused < 2) begin
                if (paused == 1) chk("pause_ack", 32'(ack0), 32'd0);
                stb = 1'b0;
                paused++;
            end else begin
                stb = 1'b1;
            end
            if (ack0 && stb) nacks++;
            ack_prev = ack0;
            stb_prev = stb;
        end
        cyc0 = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    int          lat;
    logic        ra;
    logic        re;
    logic        tl;
    int          nacks;
    int          ncyc;
    logic        eack;
    logic [31:0] rd_exp [8];
    logic [31:0] w4 [8] = '{32'hB0B00003, 32'hB0B00000, 32'hB0B00001, 32'hB0B00002,
                            32'h0, 32'h0, 32'h0, 32'h0};

    initial begin
        rst_n = 1'b0; adr = '0; sel = '0; we = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0;
        stb = 1'b0; dat_w = '0; cti = '0; bte = '0;
        #12;
        chk("reset_ack", 32'(ack0), 32'd0);
        chk("reset_err", 32'(err0), 32'd0);
        chk("reset_dat", dat0, 32'd0);
        chk("reset_dat1", dat1, 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Classic write then read, no wait states.
        classic(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ra, re, tl);
        chk("t1_wr_lat", 32'(lat), 32'd1);
        chk("t1_wr_ack", 32'(ra), 32'd1);
        chk("t1_wr_pulse", 32'(tl), 32'd0);
        classic(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, ra, re, tl);
        chk("t1_rd_lat", 32'(lat), 32'd1);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        chk("t1_rd_pulse", 32'(tl), 32'd0);

        // Byte lanes.
        classic(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, lat, ra, re, tl);
        classic(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, lat, ra, re, tl);
        classic(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, lat, ra, re, tl);
        chk("t2_lanes", rd, 32'h11BB33DD);

        // Linear read burst of 8 from 0x100.
        for (int i = 0; i < 8; i++) begin
            rd_exp[i] = 32'hC0DE0040 + 32'(i);
            classic(1'b0, 1'b1, 32'h100 + 32'(4 * i), rd_exp[i], 4'hF, rd, lat, ra, re, tl);
        end
        burst(1'b0, 32'h100, 2'b00, 8, rd_exp, -1, -1, nacks, ncyc, eack);
        chk("t3_nacks", 32'(nacks), 32'd8);
        chk("t3_ncyc", 32'(ncyc), 32'd10);
        chk("t3_end_ack", 32'(eack), 32'd0);

        // Wrap4 write burst from word 3 with a two-cycle stb pause.
        burst(1'b1, 32'h0C, 2'b01, 4, w4, 2, -1, nacks, ncyc, eack);
        chk("t4_nacks", 32'(nacks), 32'd4);
        chk("t4_ncyc", 32'(ncyc), 32'd9);
        chk("t4_end_ack", 32'(eack), 32'd0);
        for (int i = 0; i < 4; i++) begin
            classic(1'b0, 1'b0, 32'(4 * i), 32'h0, 4'hF, rd, lat, ra, re, tl);
            chk($sformatf("t4_word%0d", i), rd, 32'hB0B00000 + 32'(i));
        end
        classic(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, ra, re, tl);
        chk("t4_word4_untouched", rd, 32'hDEADBEEF);

        // Out-of-range write on dut0.
        classic(1'b0, 1'b1, 32'h4000, 32'hBAD0BAD0, 4'hF, rd, lat, ra, re, tl);
        chk("t5_err", 32'(re), 32'd1);
        chk("t5_err_noack", 32'(ra), 32'd0);
        chk("t5_err_lat", 32'(lat), 32'd1);
        chk("t5_err_pulse", 32'(tl), 32'd0);
        classic(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, rd, lat, ra, re, tl);
        chk("t5_ram_unchanged", rd, 32'hB0B00000);

        // Three wait states on dut1.
        classic(1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, rd, lat, ra, re, tl);
        chk("t5w_wr_lat", 32'(lat), 32'd4);
        classic(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, rd, lat, ra, re, tl);
        chk("t5w_rd_lat", 32'(lat), 32'd4);
        chk("t5w_rd_data", rd, 32'h5A5A5A5A);
        chk("t5w_rd_pulse", 32'(tl), 32'd0);
        classic(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF, rd, lat, ra, re, tl);
        chk("t5w_err", 32'(re), 32'd1);
        chk("t5w_err_lat", 32'(lat), 32'd4);

        // Write abandoned by dropping cyc before its ack is discarded.
        adr = 32'h30; we = 1'b1; dat_w = 32'h12345678; sel = 4'hF; cti = 3'b000;
        cyc1 = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_ack", 32'(ack1), 32'd0);
        classic(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, rd, lat, ra, re, tl);
        chk("abort_discarded", rd, 32'h5A5A5A5A);

        // Asynchronous reset during beat 3 of a burst.
        burst(1'b0, 32'h100, 2'b00, 8, rd_exp, -1, 3, nacks, ncyc, eack);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        classic(1'b0, 1'b0, 32'h104, 32'h0, 4'hF, rd, lat, ra, re, tl);
        chk("t6_after_reset", rd, 32'hC0DE0041);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
